// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 key-matrix scanner: matrix geometry,
// column-state encoding with its active-low column drive, and the mapping
// from (column, row) to a bit position in the 16-key vector.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    localparam logic [NUM_COLS-1:0] COL0_DRIVE = 4'b1110;
    localparam logic [NUM_COLS-1:0] COL1_DRIVE = 4'b1101;
    localparam logic [NUM_COLS-1:0] COL2_DRIVE = 4'b1011;
    localparam logic [NUM_COLS-1:0] COL3_DRIVE = 4'b0111;

    // Bit position of a key in the frame / key_out vector.
    function automatic int key_index(input int col, input int row);
        return col * NUM_ROWS + row;
    endfunction

    // Active-low column drive pattern for a given scan state.
    function automatic logic [NUM_COLS-1:0] col_drive(input col_state_e state);
        case (state)
            COL0:    return COL0_DRIVE;
            COL1:    return COL1_DRIVE;
            COL2:    return COL2_DRIVE;
            COL3:    return COL3_DRIVE;
            default: return COL0_DRIVE;
        endcase
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser bringing the asynchronous, active-low matrix rows
// into the clk_in domain. Resets to all-ones, i.e. "no row pulled low".
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] sync1_d, sync1_q;
    logic [WIDTH-1:0] sync2_d, sync2_q;

    // Next values simply shift the raw input down the two-stage chain.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
    end

    // Synchroniser flops, released rows idle high.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_out = sync2_q;

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 key-matrix scanner with frame-level debounce.
// One column is driven low per SCAN_DIV cycles; the synchronised rows are
// captured at the end of each column slot into a 16-bit frame. key_out is
// reloaded only once DEBOUNCE_SCANS consecutive frames agree, and key_press
// pulses for one cycle on each newly pressed key.
// Optional build macro MATRIX_KEY_SINGLE_PRIORITY_EN: when defined, the
// debounced frame is reduced to its lowest-index pressed key before it is
// loaded into key_out (debounce still runs on the raw frame).
module matrix_key_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]     DEB_MAX  = 8'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_sync;

    logic [DIV_W-1:0]    div_d, div_q;
    col_state_e          state_d, state_q;
    logic [NUM_KEYS-1:0] frame_d, frame_q;
    logic [NUM_KEYS-1:0] prev_d, prev_q;
    logic [7:0]          stable_d, stable_q;
    logic [NUM_KEYS-1:0] key_out_d, key_out_q;
    logic [NUM_KEYS-1:0] key_press_d, key_press_q;

    logic                scan_tick;
    logic [NUM_KEYS-1:0] new_frame;
    logic [NUM_KEYS-1:0] reduced_frame;

    key_sync #(
        .WIDTH (NUM_ROWS)
    ) u_key_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .async_in (row_in),
        .sync_out (row_sync)
    );

    assign scan_tick = (div_q == DIV_LAST);

    // Current frame with the active column's slice overwritten by the
    // pressed-high view of the synchronised rows.
    always_comb begin
        new_frame = frame_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            new_frame[key_index(int'(state_q), r)] = ~row_sync[r];
        end
    end

    // Vector that will be loaded into key_out once the frame is stable.
    always_comb begin
`ifdef MATRIX_KEY_SINGLE_PRIORITY_EN
        reduced_frame = new_frame & (~new_frame + NUM_KEYS'(1));
`else
        reduced_frame = new_frame;
`endif
    end

    // Divider, column FSM, frame assembly and debounce next-state logic.
    always_comb begin
        div_d       = scan_tick ? '0 : div_q + DIV_W'(1);
        state_d     = state_q;
        frame_d     = frame_q;
        prev_d      = prev_q;
        stable_d    = stable_q;
        key_out_d   = key_out_q;
        key_press_d = '0;

        if (scan_tick) begin
            frame_d = new_frame;
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                COL3:    state_d = COL0;
                default: state_d = COL0;
            endcase

            if (state_q == COL3) begin
                if (new_frame == prev_q) begin
                    stable_d = (stable_q >= DEB_MAX) ? DEB_MAX : stable_q + 8'd1;
                end else begin
                    stable_d = 8'd1;
                end
                prev_d = new_frame;

                if (stable_d >= DEB_MAX) begin
                    key_out_d   = reduced_frame;
                    key_press_d = reduced_frame & ~key_out_q;
                end
            end
        end
    end

    // State registers; reset restarts the scan at column 0 with an idle,
    // already-stable all-released history.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            div_q       <= '0;
            state_q     <= COL0;
            frame_q     <= '0;
            prev_q      <= '0;
            stable_q    <= DEB_MAX;
            key_out_q   <= '0;
            key_press_q <= '0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            key_out_q   <= key_out_d;
            key_press_q <= key_press_d;
        end
    end

    assign col_out   = col_drive(state_q);
    assign key_out   = key_out_q;
    assign key_press = key_press_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Scoreboard bench for matrix_key_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A matrix model turns a "pressed" key vector into row levels. Stimulus
// holds one key vector per frame and pushes the frame-level debounce
// prediction; a monitor pops it whenever the DUT wraps from column 3 to 0.
module tb_matrix_key_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME_CYCLES   = 4 * SCAN_DIV;

    typedef struct {
        logic [15:0] ko;
        logic [15:0] kp;
    } exp_t;

    logic        clk_in;
    logic        rst_n_in;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_out;
    logic [15:0] key_press;

    logic [15:0] pressed;
    exp_t        sb[$];
    int          vectors;
    int          miscompares;

    logic [15:0] m_prev;
    int          m_count;
    logic [15:0] m_ko;

    matrix_key_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_out   (key_out),
        .key_press (key_press)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Key matrix: a pressed key shorts its row to a column being driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_out[c] == 1'b0 && pressed[c * 4 + r]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Lowest-index pressed key only, or the whole vector.
    function automatic logic [15:0] reduce_keys(input logic [15:0] v);
`ifdef MATRIX_KEY_SINGLE_PRIORITY_EN
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 16'(1) << i;
        end
        return 16'h0000;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        m_prev  = 16'h0000;
        m_count = DEBOUNCE_SCANS;
        m_ko    = 16'h0000;
    endtask

    // Hold one key vector for a full frame and predict the frame-end outputs.
    task automatic applyStimulus(input logic [15:0] keys);
        exp_t e;
        logic [15:0] red;
        pressed = keys;
        if (keys == m_prev) begin
            if (m_count < DEBOUNCE_SCANS) m_count++;
        end else begin
            m_count = 1;
        end
        m_prev = keys;
        e.kp = 16'h0000;
        if (m_count >= DEBOUNCE_SCANS) begin
            red  = reduce_keys(keys);
            e.kp = red & ~m_ko;
            m_ko = red;
        end
        e.ko = m_ko;
        sb.push_back(e);
        repeat (FRAME_CYCLES) @(negedge clk_in);
    endtask

    // One-cycle reset pulse taken a few cycles into a frame.
    task automatic reset_pulse();
        rst_n_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        checkOutput("reset_key_out", key_out, 16'h0000);
        checkOutput("reset_col_out", {12'h000, col_out}, 16'h000E);
        checkOutput("reset_key_press", key_press, 16'h0000);
    endtask

    // Monitor: column sequence every cycle, scoreboard pop on each frame wrap,
    // and quiet key_press / steady key_out everywhere else.
    initial begin
        int          edges;
        logic [3:0]  prev_col;
        logic [15:0] exp_ko;
        logic [3:0]  exp_col;
        exp_t        e;
        edges    = 0;
        prev_col = 4'hF;
        exp_ko   = 16'h0000;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_n_in == 1'b0) begin
                edges  = 0;
                exp_ko = 16'h0000;
                sb.delete();
                checkOutput("mon_reset_col", {12'h000, col_out}, 16'h000E);
                checkOutput("mon_reset_key_out", key_out, 16'h0000);
            end else begin
                edges++;
                exp_col = ~(4'b0001 << ((edges / SCAN_DIV) % 4));
                checkOutput("col_out_seq", {12'h000, col_out}, {12'h000, exp_col});
                if (prev_col == 4'b0111 && col_out == 4'b1110) begin
                    if (sb.size() == 0) begin
                        checkOutput("sb_underflow", 16'h0001, 16'h0000);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("frame_key_out", key_out, e.ko);
                        checkOutput("frame_key_press", key_press, e.kp);
                        exp_ko = e.ko;
                    end
                end else begin
                    checkOutput("idle_key_press", key_press, 16'h0000);
                    checkOutput("hold_key_out", key_out, exp_ko);
                end
            end
            prev_col = col_out;
        end
    end

    initial begin
        logic [15:0] cur;
        vectors     = 0;
        miscompares = 0;
        pressed     = 16'h0000;
        rst_n_in    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        checkOutput("init_key_out", key_out, 16'h0000);
        checkOutput("init_col_out", {12'h000, col_out}, 16'h000E);

        // Idle scanning.
        repeat (10) applyStimulus(16'h0000);
        // Key 9 press, then release.
        repeat (5) applyStimulus(16'h0200);
        repeat (4) applyStimulus(16'h0000);
        // Key 5 bouncing frame-to-frame, then held.
        applyStimulus(16'h0020);
        applyStimulus(16'h0000);
        applyStimulus(16'h0020);
        applyStimulus(16'h0000);
        repeat (4) applyStimulus(16'h0020);
        // Keys 3 and 12 together.
        repeat (4) applyStimulus(16'h1008);
        repeat (3) applyStimulus(16'h0000);
        // Key 9 reported, then a mid-frame reset and fresh re-report.
        repeat (4) applyStimulus(16'h0200);
        pressed = 16'h0200;
        sb.push_back('{ko: 16'h0200, kp: 16'h0000});
        repeat (7) @(negedge clk_in);
        reset_pulse();
        repeat (4) applyStimulus(16'h0200);

        // Randomised frames, biased towards repeats so debounce completes.
        cur = 16'h0200;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                cur = 16'($urandom) & 16'($urandom) & 16'($urandom);
            end
            applyStimulus(cur);
        end

        checkOutput("sb_drained", 16'(sb.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_key_scan.md
Name: matrix_key_scan

Overview:
Scans a 4x4 mechanical key matrix, debounces it and produces the high-active 16-bit key vector consumed by the beeper/tone stage (key_out). It drives one column low at a time, samples the active-low rows and assembles a full 16-key frame. key_out changes only after a frame has been identical for DEBOUNCE_SCANS consecutive scans. It sits between the board key-matrix pins and the tone/PWM chain.

Parameters:
- SCAN_DIV, 12000, clk_in cycles each column is driven before it is sampled; legal range >=4.
- DEBOUNCE_SCANS, 3, number of consecutive identical full frames required to update key_out; legal range 1..255.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- row_in  input  4  matrix rows, active-low (pulled up externally), asynchronous to clk_in.
- col_out  output  4  matrix columns, one-hot active-low drive.
- key_out  output  16  debounced key state, 1 = pressed; index = col*4 + row.
- key_press  output  16  one-cycle pulse per key on each debounced 0->1 transition of key_out.

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - col_out=4'b1110; key_out=0; key_press=0.
  - Divider=0; column index=0; previous frame=0; stable count=DEBOUNCE_SCANS, so the idle state counts as stable.
  - Partial frame is discarded; scanning resumes from column 0.
- Synchronisation: row_in passes through a 2-FF synchroniser before use. SCAN_DIV>=4 guarantees synchronised rows have settled before sampling.
- Divider: counts 0..SCAN_DIV-1 and wraps. The cycle where it equals SCAN_DIV-1 is the "scan tick".
- Column FSM, states COL0->COL1->COL2->COL3->COL0, advancing on each scan tick:
  - col_out per state: COL0=1110, COL1=1101, COL2=1011, COL3=0111.
  - On a scan tick in COLc: frame bits [c*4+3 : c*4] <= ~row_sync, then advance.
- Frame completion happens on the scan tick in COL3; one full frame = 4*SCAN_DIV cycles. Let new_frame be the frame including the bits sampled that cycle.
  - If new_frame == previous frame: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: stable count = 1.
  - Previous frame <= new_frame.
  - If the updated stable count >= DEBOUNCE_SCANS: key_out <= new_frame and key_press <= new_frame & ~key_out, both visible the cycle after completion.
  - key_press is 0 in every other cycle.
- DEBOUNCE_SCANS=1: key_out follows every frame.
- Bounce shorter than one frame that alters a frame restarts the count. key_out never glitches.
- Release is debounced identically to press; a release produces no key_press pulse.
- Simultaneous keys: all pressed keys are reported (unless the optional feature is enabled). Ghosting is not resolved.
- Latency: a press stable before frame k starts appears in key_out 1 cycle after frame k+DEBOUNCE_SCANS-1 completes.

Optional Feature:
- Macro: MATRIX_KEY_SINGLE_PRIORITY_EN.
- Defined: the debounced frame is reduced to its lowest-index set bit before loading key_out, so at most one key_out bit is set. key_press is computed from the reduced vector. This gives the tone stage a single unambiguous key.
- Undefined: key_out carries every debounced pressed key.
- Debounce operates on the raw frame in both cases.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16.
  - Column-state enum COL0..COL3 and its col_out encoding constants.
  - A key-index helper (col*NUM_ROWS+row).
- One sub-module: key_sync, a 4-bit 2-FF synchroniser for row_in.
- Divider, FSM, frame assembly and debounce stay in matrix_key_scan.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3 unless stated):
1. Reset, no keys, run 10 frames -> col_out cycles 1110,1101,1011,0111, each held 4 cycles; key_out=0; key_press never pulses.
2. Hold row1 low only while col_out=1011 (key 9) from before frame 0 -> key_out=16'h0200 and key_press=16'h0200 for one cycle, exactly 1 cycle after frame 2 completes.
3. Key 9 held, release before frame k -> key_out returns to 0 one cycle after frame k+2 completes; no key_press pulse.
4. Key 5 bounced (toggled each frame for 4 frames) then held -> key_out stays 0 until 3 identical frames; then 16'h0020.
5. Keys 3 and 12 held together -> key_out=16'h1008. With MATRIX_KEY_SINGLE_PRIORITY_EN defined -> key_out=16'h0008.
6. Assert rst_n_in for one cycle mid-frame while key_out=16'h0200 -> next cycle key_out=0 and col_out=1110; key re-reported after 3 fresh frames.
